text_scroller: RTL and testbench

- Parametrised successor to the fixed-text column scroller.
- The message is no longer hard-coded: a writable character-code buffer is loaded at run time.
- A glyph ROM sub-module turns each character into columns, and the block streams one 7-row column per clock to the LED-matrix / shift-register output.
- Adds run/pause, clear, invert mode, frame/character markers and a full flag.

---
 rtl/text_pkg.sv | 43 ++++
 rtl/char_rom.sv | 79 +++++++
 rtl/text_scroller.sv | 117 +++++++++++
 tb/tb_text_scroller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared definitions for the text scroller: character code map, glyph
// geometry and the column bit-order used on col_out.
package text_pkg;

  localparam int CODE_W     = 6;
  localparam int GLYPH_COLS = 8;
  localparam int GLYPH_ROWS = 7;

  // Character code map. Codes above the punctuation range render blank.
  localparam logic [CODE_W-1:0] CODE_SPACE    = 6'd0;
  localparam logic [CODE_W-1:0] CODE_A        = 6'd1;
  localparam logic [CODE_W-1:0] CODE_Z        = 6'd26;
  localparam logic [CODE_W-1:0] CODE_DIGIT0   = 6'd27;
  localparam logic [CODE_W-1:0] CODE_DIGIT9   = 6'd36;
  localparam logic [CODE_W-1:0] CODE_PERIOD   = 6'd37;
  localparam logic [CODE_W-1:0] CODE_COMMA    = 6'd38;
  localparam logic [CODE_W-1:0] CODE_EXCLAIM  = 6'd39;
  localparam logic [CODE_W-1:0] CODE_QUESTION = 6'd40;
  localparam logic [CODE_W-1:0] CODE_DASH     = 6'd41;
  localparam logic [CODE_W-1:0] CODE_COLON    = 6'd42;

  // col_out bit order: bit0 is the top LED row, bit6 the bottom row and
  // bit7 is a pad that is always driven low.
  localparam int COL_TOP_BIT    = 0;
  localparam int COL_BOTTOM_BIT = 6;
  localparam int COL_PAD_BIT    = 7;

  typedef logic [GLYPH_ROWS-1:0] glyph_col_t;

  // One registered output beat of the scanner.
  typedef struct packed {
    logic [7:0] col;
    logic       valid;
    logic       char_start;
    logic       frame_start;
  } col_beat_t;

  // Widen a 7-row glyph column to the 8-bit output format with the pad low.
  function automatic logic [7:0] pad_column(input glyph_col_t g);
    return {1'b0, g};
  endfunction

endpackage

// File: rtl/char_rom.sv
// Combinational glyph ROM: maps a character code and a column number to the
// 7-row bitmap of that column. Each glyph uses columns 0..5; columns 6 and 7
// are always blank so characters are separated by a gap when CHAR_W > 6.
// Table entries list column 0 in the most significant byte.
module char_rom
  import text_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic [2:0]        col,
  output logic [6:0]        glyph
);

  logic [47:0] cols;

  // Look up the six drawable columns of the selected character.
  always_comb begin
    cols = 48'h0;
    case (code)
      6'd1:  cols = 48'h7C_12_11_11_12_7C;
      6'd2:  cols = 48'h7F_49_49_49_36_00;
      6'd3:  cols = 48'h3E_41_41_41_22_00;
      6'd4:  cols = 48'h7F_41_41_22_1C_00;
      6'd5:  cols = 48'h7F_49_49_49_41_00;
      6'd6:  cols = 48'h7F_09_09_09_01_00;
      6'd7:  cols = 48'h3E_41_49_49_7A_00;
      6'd8:  cols = 48'h7F_08_08_08_7F_00;
      6'd9:  cols = 48'h00_41_7F_41_00_00;
      6'd10: cols = 48'h20_40_41_3F_01_00;
      6'd11: cols = 48'h7F_08_14_22_41_00;
      6'd12: cols = 48'h7F_40_40_40_40_00;
      6'd13: cols = 48'h7F_02_0C_02_7F_00;
      6'd14: cols = 48'h7F_04_08_10_7F_00;
      6'd15: cols = 48'h3E_41_41_41_3E_00;
      6'd16: cols = 48'h7F_09_09_09_06_00;
      6'd17: cols = 48'h3E_41_51_21_5E_00;
      6'd18: cols = 48'h7F_09_19_29_46_00;
      6'd19: cols = 48'h46_49_49_49_31_00;
      6'd20: cols = 48'h01_01_7F_01_01_00;
      6'd21: cols = 48'h3F_40_40_40_3F_00;
      6'd22: cols = 48'h1F_20_40_20_1F_00;
      6'd23: cols = 48'h3F_40_38_40_3F_00;
      6'd24: cols = 48'h63_14_08_14_63_00;
      6'd25: cols = 48'h07_08_70_08_07_00;
      6'd26: cols = 48'h61_51_49_45_43_00;
      6'd27: cols = 48'h3E_61_51_49_45_3E;
      6'd28: cols = 48'h00_42_7F_40_00_00;
      6'd29: cols = 48'h42_61_51_49_46_00;
      6'd30: cols = 48'h21_41_45_4B_31_00;
      6'd31: cols = 48'h18_14_12_7F_10_00;
      6'd32: cols = 48'h27_45_45_45_39_00;
      6'd33: cols = 48'h3C_4A_49_49_30_00;
      6'd34: cols = 48'h01_71_09_05_03_00;
      6'd35: cols = 48'h36_49_49_49_36_00;
      6'd36: cols = 48'h06_49_49_29_1E_00;
      6'd37: cols = 48'h00_60_60_00_00_00;
      6'd38: cols = 48'h00_50_30_00_00_00;
      6'd39: cols = 48'h00_00_5F_00_00_00;
      6'd40: cols = 48'h02_01_51_09_06_00;
      6'd41: cols = 48'h08_08_08_08_08_00;
      6'd42: cols = 48'h00_36_36_00_00_00;
      default: cols = 48'h0;
    endcase
  end

  // Pick the requested column; columns 6 and 7 form the blank gap.
  always_comb begin
    glyph = 7'h00;
    case (col)
      3'd0: glyph = cols[46:40];
      3'd1: glyph = cols[38:32];
      3'd2: glyph = cols[30:24];
      3'd3: glyph = cols[22:16];
      3'd4: glyph = cols[14:8];
      3'd5: glyph = cols[6:0];
      default: glyph = 7'h00;
    endcase
  end

endmodule

// File: rtl/text_scroller.sv
// Run-time loadable column scroller. Character codes are appended to a
// message buffer; while running, the address stage walks every column of
// every stored character and the output stage registers one 7-row column
// per clock, with character and frame markers for the downstream driver.
module text_scroller
  import text_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int CODE_W  = text_pkg::CODE_W,
  parameter int CHAR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              run,
  input  logic              invert,
  output logic [7:0]        col_out,
  output logic              col_valid,
  output logic              char_start,
  output logic              frame_start,
  output logic              full
);

  localparam int IDX_W = $clog2(MSG_LEN);
  localparam int LEN_W = IDX_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MSG_LEN);
  localparam logic [2:0]       COL_LAST = 3'(CHAR_W - 1);

  logic [CODE_W-1:0] msg_buf [MSG_LEN];
  logic [LEN_W-1:0]  len;
  logic [IDX_W-1:0]  char_idx;
  logic [2:0]        col_idx;

  logic              scan_active;
  logic              can_write;
  logic              col_wrap;
  logic              char_wrap;
  logic [CODE_W-1:0] cur_code;
  logic [6:0]        glyph;
  col_beat_t         beat_next;
  col_beat_t         beat_q;

  char_rom u_char_rom (
    .code  (cur_code),
    .col   (col_idx),
    .glyph (glyph)
  );

  // Decode scan and write conditions from the current address state; the
  // wrap test deliberately uses the live length so appended characters join
  // the scan on the next pass.
  always_comb begin
    scan_active = run && (len != '0);
    can_write   = wr_en && !clr && (len != LEN_MAX);
    col_wrap    = (col_idx == COL_LAST);
    char_wrap   = ({1'b0, char_idx} == (len - LEN_W'(1)));
    cur_code    = msg_buf[char_idx];
  end

  // Message storage is not reset; stale entries stay hidden behind len.
  always_ff @(posedge clk) begin
    if (!reset && can_write) begin
      msg_buf[len[IDX_W-1:0]] <= wr_code;
    end
  end

  // Length and scan address counters; clear beats a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      len      <= '0;
      char_idx <= '0;
      col_idx  <= '0;
    end else begin
      if (can_write) begin
        len <= len + LEN_W'(1);
      end
      if (scan_active) begin
        if (col_wrap) begin
          col_idx  <= '0;
          char_idx <= char_wrap ? '0 : char_idx + IDX_W'(1);
        end else begin
          col_idx <= col_idx + 3'd1;
        end
      end
    end
  end

  // Form the next output beat from the address stage; idle beats are all zero.
  always_comb begin
    beat_next = '0;
    if (scan_active) begin
      beat_next.col         = pad_column(glyph ^ (invert ? 7'h7F : 7'h00));
      beat_next.valid       = 1'b1;
      beat_next.char_start  = (col_idx == 3'd0);
      beat_next.frame_start = (col_idx == 3'd0) && (char_idx == '0);
    end
  end

  // Output register plus the full flag, which trails len by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q <= '0;
      full   <= 1'b0;
    end else begin
      beat_q <= beat_next;
      full   <= (len == LEN_MAX);
    end
  end

  assign col_out     = beat_q.col;
  assign col_valid   = beat_q.valid;
  assign char_start  = beat_q.char_start;
  assign frame_start = beat_q.frame_start;

endmodule

// File: tb/tb_text_scroller.sv
// Self-checking bench for text_scroller: directed scenarios plus randomized
// traffic compared against a stream-position reference model.
module tb_text_scroller;

  localparam int MSG_LEN = 32;
  localparam int CHAR_W  = 8;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       wr_en;
  logic [5:0] wr_code;
  logic       run;
  logic       invert;
  logic [7:0] col_out;
  logic       col_valid;
  logic       char_start;
  logic       frame_start;
  logic       full;

  int checks = 0;
  int errors = 0;

  logic [5:0] model_q[$];
  int         model_pos;
  logic [7:0] exp_col;
  logic       exp_valid;
  logic       exp_cs;
  logic       exp_fs;
  logic       exp_full;

  logic [5:0] code_pool [8] = '{6'd0, 6'd1, 6'd8, 6'd9, 6'd27, 6'd28, 6'd50, 6'd63};
  logic [7:0] seq_a0 [16] = '{8'h7C, 8'h12, 8'h11, 8'h11, 8'h12, 8'h7C, 8'h00, 8'h00,
                              8'h3E, 8'h61, 8'h51, 8'h49, 8'h45, 8'h3E, 8'h00, 8'h00};

  text_scroller #(.MSG_LEN(MSG_LEN), .CODE_W(6), .CHAR_W(CHAR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr),
    .wr_en       (wr_en),
    .wr_code     (wr_code),
    .run         (run),
    .invert      (invert),
    .col_out     (col_out),
    .col_valid   (col_valid),
    .char_start  (char_start),
    .frame_start (frame_start),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference glyph columns for the codes the bench writes.
  function automatic logic [6:0] tb_glyph(input logic [5:0] code, input int col);
    logic [7:0] g [6];
    case (code)
      6'd1:    g = '{8'h7C, 8'h12, 8'h11, 8'h11, 8'h12, 8'h7C};
      6'd8:    g = '{8'h7F, 8'h08, 8'h08, 8'h08, 8'h7F, 8'h00};
      6'd9:    g = '{8'h00, 8'h41, 8'h7F, 8'h41, 8'h00, 8'h00};
      6'd27:   g = '{8'h3E, 8'h61, 8'h51, 8'h49, 8'h45, 8'h3E};
      6'd28:   g = '{8'h00, 8'h42, 8'h7F, 8'h40, 8'h00, 8'h00};
      default: g = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    endcase
    if (col >= 6) return 7'h00;
    return g[col][6:0];
  endfunction

  // Drive one cycle of inputs, predict the outputs of that edge, then wait
  // until just after the edge. The model treats the message as a flat stream
  // of len*CHAR_W columns with a single read position.
  task automatic drive_cycle(input bit r_run, input bit r_wr, input logic [5:0] r_code,
                             input bit r_clr, input bit r_inv, input bit r_rst);
    int old_len;
    reset   = r_rst;
    clr     = r_clr;
    wr_en   = r_wr;
    wr_code = r_code;
    run     = r_run;
    invert  = r_inv;
    old_len = model_q.size();
    if (r_rst) begin
      exp_col = 8'h00; exp_valid = 1'b0; exp_cs = 1'b0; exp_fs = 1'b0; exp_full = 1'b0;
      model_q.delete();
      model_pos = 0;
    end else begin
      exp_full  = (old_len == MSG_LEN);
      exp_valid = r_run && (old_len > 0);
      if (exp_valid) begin
        exp_col = {1'b0, tb_glyph(model_q[model_pos / CHAR_W], model_pos % CHAR_W) ^ (r_inv ? 7'h7F : 7'h00)};
        exp_cs  = (model_pos % CHAR_W) == 0;
        exp_fs  = (model_pos == 0);
      end else begin
        exp_col = 8'h00; exp_cs = 1'b0; exp_fs = 1'b0;
      end
      if (r_clr) begin
        model_q.delete();
        model_pos = 0;
      end else begin
        if (exp_valid) model_pos = (model_pos + 1) % (old_len * CHAR_W);
        if (r_wr && old_len < MSG_LEN) model_q.push_back(r_code);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(0, 0, 6'd0, 0, 0, 1);
    drive_cycle(0, 0, 6'd0, 0, 0, 1);
    checks++; if (col_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_col_out: got %h expected 00", col_out); end
    checks++; if (col_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_col_valid: got %b expected 0", col_valid); end
    checks++; if (char_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_char_start: got %b expected 0", char_start); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start: got %b expected 0", frame_start); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    drive_cycle(0, 0, 6'd0, 0, 0, 0);
  endtask

  task automatic test_empty_run();
    for (int i = 0; i < 50; i++) begin
      drive_cycle(1, 0, 6'd0, 0, 0, 0);
      checks++;
      if (col_valid !== 1'b0 || col_out !== 8'h00 || full !== 1'b0) begin
        errors++;
        $display("[TB] FAIL empty_run cycle %0d: got valid=%b col=%h full=%b expected 0/00/0", i, col_valid, col_out, full);
      end
    end
  endtask

  task automatic test_known_pattern(input bit inv);
    logic [7:0] want;
    drive_cycle(0, 0, 6'd0, 1, 0, 0);
    drive_cycle(0, 1, 6'd1, 0, 0, 0);
    drive_cycle(0, 1, 6'd27, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      drive_cycle(1, 0, 6'd0, 0, inv, 0);
      want = seq_a0[i % 16] ^ (inv ? 8'h7F : 8'h00);
      checks++;
      if (col_valid !== 1'b1 || col_out !== want) begin
        errors++;
        $display("[TB] FAIL pattern inv=%0d col %0d: got valid=%b col=%h expected 1/%h", inv, i, col_valid, col_out, want);
      end
      checks++;
      if (frame_start !== ((i % 16) == 0) || char_start !== ((i % 8) == 0)) begin
        errors++;
        $display("[TB] FAIL markers inv=%0d col %0d: got fs=%b cs=%b expected fs=%0d cs=%0d",
                 inv, i, frame_start, char_start, (i % 16) == 0, (i % 8) == 0);
      end
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 6'd0, 0, 0, 0);
    checks++;
    if (col_out !== 8'h11) begin errors++; $display("[TB] FAIL pause_pre: got %h expected 11", col_out); end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, 0, 6'd0, 0, 0, 0);
      checks++;
      if (col_valid !== 1'b0 || col_out !== 8'h00) begin
        errors++;
        $display("[TB] FAIL pause_hold %0d: got valid=%b col=%h expected 0/00", i, col_valid, col_out);
      end
    end
    drive_cycle(1, 0, 6'd0, 0, 0, 0);
    checks++;
    if (col_valid !== 1'b1 || col_out !== 8'h11 || char_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pause_resume: got valid=%b col=%h cs=%b expected 1/11/0", col_valid, col_out, char_start);
    end
    drive_cycle(1, 0, 6'd0, 0, 0, 0);
    checks++;
    if (col_out !== 8'h12) begin errors++; $display("[TB] FAIL pause_next: got %h expected 12", col_out); end
  endtask

  task automatic test_clr_with_write();
    drive_cycle(1, 1, 6'd8, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 0, 6'd0, 0, 0, 0);
      checks++;
      if (col_valid !== 1'b0 || full !== 1'b0) begin
        errors++;
        $display("[TB] FAIL clr_wr %0d: got valid=%b full=%b expected 0/0", i, col_valid, full);
      end
    end
  endtask

  task automatic test_full();
    int first_fs;
    int gap;
    bool_loop: begin end
    drive_cycle(0, 0, 6'd0, 1, 0, 0);
    for (int i = 0; i < MSG_LEN; i++) begin
      drive_cycle(0, 1, code_pool[$urandom_range(0, 7)], 0, 0, 0);
      checks++;
      if (full !== 1'b0) begin errors++; $display("[TB] FAIL full_early write %0d: got %b expected 0", i, full); end
    end
    drive_cycle(0, 1, 6'd1, 0, 0, 0);
    checks++;
    if (full !== 1'b1) begin errors++; $display("[TB] FAIL full_set: got %b expected 1", full); end
    first_fs = -1;
    gap = -1;
    for (int cyc = 0; cyc < 700 && gap < 0; cyc++) begin
      drive_cycle(1, 0, 6'd0, 0, 0, 0);
      checks++;
      if (col_out !== exp_col || col_valid !== exp_valid || char_start !== exp_cs || frame_start !== exp_fs) begin
        errors++;
        $display("[TB] FAIL full_scan cyc %0d: got col=%h v=%b cs=%b fs=%b expected col=%h v=%b cs=%b fs=%b",
                 cyc, col_out, col_valid, char_start, frame_start, exp_col, exp_valid, exp_cs, exp_fs);
      end
      if (frame_start === 1'b1) begin
        if (first_fs < 0) first_fs = cyc;
        else gap = cyc - first_fs;
      end
    end
    checks++;
    if (gap != MSG_LEN * CHAR_W) begin
      errors++;
      $display("[TB] FAIL frame_period: got %0d expected %0d", gap, MSG_LEN * CHAR_W);
    end
  endtask

  task automatic test_random();
    bit r_run, r_wr, r_clr, r_inv;
    drive_cycle(0, 0, 6'd0, 1, 0, 0);
    r_inv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r_run = ($urandom_range(0, 3) != 0);
      r_wr  = ($urandom_range(0, 4) == 0);
      r_clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) r_inv = ~r_inv;
      drive_cycle(r_run, r_wr, code_pool[$urandom_range(0, 7)], r_clr, r_inv, 0);
      checks++;
      if (col_out !== exp_col || col_valid !== exp_valid || char_start !== exp_cs ||
          frame_start !== exp_fs || full !== exp_full) begin
        errors++;
        $display("[TB] FAIL random cyc %0d: got col=%h v=%b cs=%b fs=%b full=%b expected col=%h v=%b cs=%b fs=%b full=%b",
                 i, col_out, col_valid, char_start, frame_start, full, exp_col, exp_valid, exp_cs, exp_fs, exp_full);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    drive_cycle(0, 0, 6'd0, 1, 0, 0);
    drive_cycle(0, 1, 6'd1, 0, 0, 0);
    drive_cycle(0, 1, 6'd27, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive_cycle(1, 0, 6'd0, 0, 0, 0);
    checks++;
    if (col_out !== 8'h61) begin errors++; $display("[TB] FAIL second_char: got %h expected 61", col_out); end
    drive_cycle(1, 0, 6'd0, 0, 0, 1);
    checks++;
    if (col_out !== 8'h00 || col_valid !== 1'b0 || char_start !== 1'b0 || frame_start !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got col=%h v=%b cs=%b fs=%b full=%b expected all 0",
               col_out, col_valid, char_start, frame_start, full);
    end
    drive_cycle(1, 1, 6'd8, 0, 0, 0);
    checks++;
    if (col_valid !== 1'b0) begin errors++; $display("[TB] FAIL restart_idle: got %b expected 0", col_valid); end
    drive_cycle(1, 0, 6'd0, 0, 0, 0);
    checks++;
    if (col_valid !== 1'b1 || frame_start !== 1'b1 || char_start !== 1'b1 || col_out !== 8'h7F) begin
      errors++;
      $display("[TB] FAIL restart_first: got v=%b fs=%b cs=%b col=%h expected 1/1/1/7f",
               col_valid, frame_start, char_start, col_out);
    end
  endtask

  initial begin
    test_reset();
    test_empty_run();
    test_known_pattern(1'b0);
    test_pause();
    test_known_pattern(1'b1);
    test_clr_with_write();
    test_full();
    test_random();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
